// File: rtl/dmem_resp.sv
// Data-memory responder: combinational reads, byte-lane writes, and a handshaked dump engine.
// Optional MMIO window (cycle/store counters, dump ctrl) is enabled by defining DMEM_MMIO_EN.
module dmem_resp #(
  parameter int MEM_AW     = 10,
  parameter int DUMP_WORDS = 32,
  parameter int IDX_W      = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      daddr,
  input  logic [31:0]      dwdata,
  input  logic [3:0]       dwe,
  output logic [31:0]      drdata,
  input  logic             dump_start,
  input  logic             dump_ready,
  output logic             dump_valid,
  output logic [31:0]      dump_data,
  output logic [IDX_W-1:0] dump_idx,
  output logic             dump_done,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_DONE} state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(DUMP_WORDS - 1);

  logic [31:0]       mem [2**MEM_AW];
  logic [MEM_AW-1:0] widx;
  logic [MEM_AW-1:0] dump_addr;
  logic [31:0]       mem_rd;
  logic              is_mem;
  logic              mmio_start;
  logic              start;
  state_t            state;

  assign widx      = daddr[MEM_AW+1:2];
  assign dump_addr = MEM_AW'(dump_idx);
  assign mem_rd    = mem[widx];

  // Address bits above the memory index alias; byte offset is irrelevant to word access.
  logic unused;
  assign unused = ^{daddr[31:MEM_AW+2], daddr[1:0]};

`ifdef DMEM_MMIO_EN
  logic [31:0] cyc_cnt;
  logic [31:0] st_cnt;

  assign is_mem     = ~daddr[31];
  assign mmio_start = daddr[31] && (daddr[3:2] == 2'd2) && dwe[0] && dwdata[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_cnt <= '0;
      st_cnt  <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (is_mem && (|dwe)) st_cnt <= st_cnt + 32'd1;
    end
  end

  always_comb begin
    drdata = mem_rd;
    if (!is_mem) begin
      case (daddr[3:2])
        2'd0:    drdata = cyc_cnt;
        2'd1:    drdata = st_cnt;
        2'd2:    drdata = {30'b0, dump_done, busy};
        default: drdata = '0;
      endcase
    end
  end
`else
  assign is_mem     = 1'b1;
  assign mmio_start = 1'b0;
  assign drdata     = mem_rd;
`endif

  assign start = dump_start | mmio_start;

  // Contents are intentionally not reset; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (reset && is_mem) begin
      for (int i = 0; i < 4; i++)
        if (dwe[i]) mem[widx][8*i +: 8] <= dwdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      dump_valid <= 1'b0;
      dump_done  <= 1'b0;
      busy       <= 1'b0;
      dump_idx   <= '0;
      dump_data  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_LOAD;
            dump_idx  <= '0;
            dump_done <= 1'b0;
            busy      <= 1'b1;
          end
        end
        S_LOAD: begin
          // Sampled here, so later CPU writes to this word miss the current dump.
          dump_data  <= mem[dump_addr];
          dump_valid <= 1'b1;
          state      <= S_SEND;
        end
        S_SEND: begin
          if (dump_ready) begin
            dump_valid <= 1'b0;
            if (dump_idx == LAST) begin
              state     <= S_DONE;
              dump_done <= 1'b1;
              busy      <= 1'b0;
            end else begin
              dump_idx <= dump_idx + 1'b1;
              state    <= S_LOAD;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: byte lanes, reset gating, dump streaming/stall/abort, MMIO.
module tb_dmem_resp;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] daddr = '0;
  logic [31:0] dwdata = '0;
  logic [3:0]  dwe = '0;
  logic        dump_start = 1'b0;
  logic        dump_ready = 1'b0;
  logic [31:0] drdata;
  logic        dump_valid;
  logic [31:0] dump_data;
  logic [4:0]  dump_idx;
  logic        dump_done;
  logic        busy;

  int errors = 0;
  int checks = 0;

  dmem_resp #(.MEM_AW(10), .DUMP_WORDS(32), .IDX_W(5)) dut (
    .clk(clk), .reset(reset), .daddr(daddr), .dwdata(dwdata), .dwe(dwe), .drdata(drdata),
    .dump_start(dump_start), .dump_ready(dump_ready), .dump_valid(dump_valid),
    .dump_data(dump_data), .dump_idx(dump_idx), .dump_done(dump_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    daddr = a; dwdata = d; dwe = be;
    step();
    dwe = 4'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    step(); step();
    checks++; if (dump_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", dump_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (dump_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", dump_done); end
    checks++; if (dump_idx !== 5'd0) begin errors++; $display("FAIL rst_idx got %0d exp 0", dump_idx); end
    checks++; if (dump_data !== 32'h0) begin errors++; $display("FAIL rst_data got %h exp 0", dump_data); end
    reset = 1'b1;
    wr(32'h0, 32'hA5A5_A5A5, 4'hF);
    reset = 1'b0;
    daddr = 32'h0; dwdata = 32'hFFFF_FFFF; dwe = 4'hF;
    step(); step(); step();
    dwe = 4'h0;
    reset = 1'b1;
    #1;
    checks++; if (drdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL rst_nowrite got %h exp a5a5a5a5", drdata); end
`ifdef DMEM_MMIO_EN
    daddr = 32'h8000_0000; #1;
    checks++; if (drdata !== 32'd0) begin errors++; $display("FAIL cyc_after_rst got %0d exp 0", drdata); end
    repeat (5) step();
    checks++; if (drdata !== 32'd5) begin errors++; $display("FAIL cyc_5 got %0d exp 5", drdata); end
`endif
  endtask

  task automatic test_byte_lanes();
    wr(32'h10, 32'hDEAD_BEEF, 4'b1111);
    wr(32'h10, 32'h0000_5500, 4'b0010);
    daddr = 32'h10; #1;
    checks++; if (drdata !== 32'hDEAD_55EF) begin errors++; $display("FAIL byte_lane got %h exp dead55ef", drdata); end
    daddr = 32'h1010; #1;
    checks++; if (drdata !== 32'hDEAD_55EF) begin errors++; $display("FAIL alias got %h exp dead55ef", drdata); end
    daddr = 32'h10; dwdata = 32'h1111_1111; dwe = 4'hF; #1;
    checks++; if (drdata !== 32'hDEAD_55EF) begin errors++; $display("FAIL rd_old got %h exp dead55ef", drdata); end
    step(); dwe = 4'h0; #1;
    checks++; if (drdata !== 32'h1111_1111) begin errors++; $display("FAIL rd_new got %h exp 11111111", drdata); end
  endtask

  task automatic test_dump_full();
    int c, n;
    for (int i = 0; i < 32; i++) wr(i * 4, i * 3, 4'hF);
    dump_ready = 1'b1;
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy got %b exp 1", busy); end
    c = 0; n = 0;
    while (!dump_done && c < 200) begin
      if (dump_valid && dump_ready) begin
        checks++; if (dump_idx !== 5'(n)) begin errors++; $display("FAIL full_idx got %0d exp %0d", dump_idx, n); end
        checks++; if (dump_data !== 32'(n * 3)) begin errors++; $display("FAIL full_data got %0d exp %0d", dump_data, n * 3); end
        n++;
      end
      step(); c++;
    end
    checks++; if (c !== 64) begin errors++; $display("FAIL full_done_cycle got %0d exp 64", c); end
    checks++; if (n !== 32) begin errors++; $display("FAIL full_count got %0d exp 32", n); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_end got %b exp 0", busy); end
  endtask

  task automatic test_dump_stall();
    logic        pv, pr, written;
    logic [4:0]  pidx;
    logic [31:0] pdata, exp_d;
    int n, stalls, c;
    pv = 1'b0; pr = 1'b0; pidx = '0; pdata = '0; written = 1'b0;
    n = 0; stalls = 0;
    dump_ready = 1'b0;
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    c = 1;
    while (!dump_done && c < 400) begin
      dump_ready = (c % 3 == 0);
      if (pv && !pr) begin
        stalls++;
        checks++; if (dump_idx !== pidx || dump_data !== pdata) begin
          errors++; $display("FAIL stall_stable got %0d/%h exp %0d/%h", dump_idx, dump_data, pidx, pdata);
        end
      end
      dwe = 4'h0;
      if (dump_valid && dump_idx == 5'd4 && !dump_ready && !written) begin
        daddr = 32'h14; dwdata = 32'h0000_1234; dwe = 4'hF; written = 1'b1;
      end
      if (dump_valid && dump_ready) begin
        exp_d = (n == 5) ? 32'h1234 : 32'(n * 3);
        checks++; if (dump_idx !== 5'(n)) begin errors++; $display("FAIL stall_idx got %0d exp %0d", dump_idx, n); end
        checks++; if (dump_data !== exp_d) begin errors++; $display("FAIL stall_data got %h exp %h", dump_data, exp_d); end
        n++;
      end
      pv = dump_valid; pr = dump_ready; pidx = dump_idx; pdata = dump_data;
      step(); c++;
    end
    dwe = 4'h0;
    checks++; if (dump_done !== 1'b1) begin errors++; $display("FAIL stall_done got %b exp 1", dump_done); end
    checks++; if (n !== 32) begin errors++; $display("FAIL stall_count got %0d exp 32", n); end
    checks++; if (written !== 1'b1 || stalls == 0) begin errors++; $display("FAIL stall_seen got %b/%0d exp 1/>0", written, stalls); end
  endtask

  task automatic test_reset_mid_dump();
    logic found;
    int c;
    found = 1'b0;
    dump_ready = 1'b1;
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (dump_valid && dump_idx == 5'd10) begin found = 1'b1; break; end
      step();
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL mid_reach got %b exp 1", found); end
    reset = 1'b0;
    #1;
    checks++; if (dump_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b exp 0", dump_valid); end
    checks++; if (dump_idx !== 5'd0) begin errors++; $display("FAIL mid_idx got %0d exp 0", dump_idx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b exp 0", busy); end
    step(); step();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (dump_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_abort got %b/%b exp 0/0", dump_valid, busy); end
    end
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    step();
    checks++; if (dump_valid !== 1'b1 || dump_idx !== 5'd0 || dump_data !== 32'd0) begin
      errors++; $display("FAIL mid_restart got %b/%0d/%h exp 1/0/0", dump_valid, dump_idx, dump_data);
    end
    c = 0;
    while (!dump_done && c < 200) begin step(); c++; end
    checks++; if (dump_done !== 1'b1) begin errors++; $display("FAIL mid_redone got %b exp 1", dump_done); end
  endtask

`ifdef DMEM_MMIO_EN
  task automatic test_mmio();
    int c;
    reset = 1'b0; step(); reset = 1'b1;
    dump_ready = 1'b1;
    wr(32'h8000_0008, 32'h1, 4'b0001);
    daddr = 32'h8000_0008; #1;
    checks++; if (drdata !== 32'd1) begin errors++; $display("FAIL mmio_busy got %h exp 1", drdata); end
    wr(32'h40, 32'h1, 4'hF);
    wr(32'h44, 32'h2, 4'h3);
    wr(32'h48, 32'h3, 4'h1);
    daddr = 32'h8000_0004; #1;
    checks++; if (drdata !== 32'd3) begin errors++; $display("FAIL mmio_stores got %0d exp 3", drdata); end
    daddr = 32'h8000_000C; #1;
    checks++; if (drdata !== 32'd0) begin errors++; $display("FAIL mmio_unused got %h exp 0", drdata); end
    daddr = 32'h8; #1;
    checks++; if (drdata !== 32'd6) begin errors++; $display("FAIL mmio_nomem got %h exp 6", drdata); end
    c = 0;
    while (!dump_done && c < 200) begin step(); c++; end
    daddr = 32'h8000_0008; #1;
    checks++; if (drdata !== 32'd2) begin errors++; $display("FAIL mmio_done got %h exp 2", drdata); end
  endtask
`endif

  initial begin
    test_reset();
    test_byte_lanes();
    test_dump_full();
    test_dump_stall();
    test_reset_mid_dump();
`ifdef DMEM_MMIO_EN
    test_mmio();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_resp.md
Name: dmem_resp

Overview:
Data-memory responder on the CPU data bus: the other end of the `daddr`/`drdata`/`dwdata`/`dwe` interface the CPU drives.
- Reads are combinational.
- Writes are synchronous and byte-lane enabled.
- A small MMIO window holds two performance counters and a dump control register.
- A handshaked dump engine streams the first `DUMP_WORDS` words out for end-of-run checking, so benches need no hierarchical peeking.

Parameters:
MEM_AW, 10, word-address width; memory depth = 2^MEM_AW 32-bit words
DUMP_WORDS, 32, number of words streamed by the dump engine (1..2^MEM_AW)
IDX_W, 5, width of `dump_idx`; must hold DUMP_WORDS-1

Ports:
clk  in  1  single clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = in reset)
daddr  in  32  CPU byte address
dwdata  in  32  CPU write data
dwe  in  4  byte-lane write enables, bit i -> dwdata[8i+7:8i]
drdata  out  32  read data, combinational from daddr
dump_start  in  1  pulse: begin dump
dump_ready  in  1  consumer accepts current dump word
dump_valid  out  1  dump word presented
dump_data  out  32  dump word value
dump_idx  out  IDX_W  word index of dump_data
dump_done  out  1  dump finished, held until next start
busy  out  1  dump in progress

Behaviour:
- Decode:
  - daddr[31]=0 -> memory; word index = daddr[MEM_AW+1:2]; upper bits are ignored (aliasing).
  - daddr[31]=1 -> MMIO; register select = daddr[3:2].
- Memory read: `drdata` = mem[idx], combinational, no latency. Memory contents are not reset.
- Memory write: at posedge clk, while reset=1, each lane with dwe[i]=1 updates byte i. No write occurs while reset=0. Read in the same cycle as a write returns the old value.
- MMIO map:
  - 0x8000_0000: cycle counter (RO). +1 every clock with reset=1; wraps 0xFFFF_FFFF->0.
  - 0x8000_0004: store counter (RO). +1 on each cycle with dwe!=0 to the memory region; wraps.
  - 0x8000_0008: dump ctrl. Read = {30'b0, dump_done, busy}. A write with dwe[0]=1 and dwdata[0]=1 acts as dump_start.
  - 0x8000_000C: reads 0.
  - Writes to RO or unused MMIO addresses are ignored.
- Dump FSM:
  - IDLE: on start -> LOAD, with dump_idx=0 and dump_done=0.
  - LOAD (1 cycle): dump_data <= mem[dump_idx]; -> SEND.
  - SEND: dump_valid=1.
    - dump_valid=1 & dump_ready=1 & dump_idx<DUMP_WORDS-1: dump_idx+1, -> LOAD.
    - Handshake with dump_idx==DUMP_WORDS-1: -> DONE.
  - DONE: dump_done=1 held; start -> LOAD, restarting at index 0.
- busy=1 in LOAD and SEND.
- While dump_valid=1 and dump_ready=0, dump_data and dump_idx stay stable.
- CPU writes to the word currently latched are not reflected until the next dump. Writes to later words are reflected, because they are sampled at their LOAD.
- Start (pin or MMIO) while busy is ignored. Pin and MMIO start in the same cycle count as one start.
- Throughput is 1 word per 2 cycles with ready held high. With DUMP_WORDS=32, done is asserted 64 cycles after start.
- Reset values (reset=0, async, mid-operation included): state IDLE, dump_valid=0, dump_done=0, busy=0, dump_idx=0, dump_data=0, both counters 0. An in-flight dump is aborted with no further words.

Optional Feature:
Macro DMEM_MMIO_EN.
- Defined: MMIO window present exactly as above.
- Undefined:
  - daddr[31] is ignored and every address maps to memory.
  - Counters and the ctrl register are absent.
  - The dump starts only via the dump_start pin.

Test Plan:
- Write 0xDEADBEEF to 0x10 with dwe=1111, then dwe=0010 with dwdata=0x0000_5500 -> read 0x10 returns 0xDEAD55EF.
- Assert reset=0 while dwe=1111 to 0x0 over 3 edges -> mem[0] unchanged; cycle counter reads 0 right after release, then 5 after 5 edges.
- Preload mem[i]=i*3, pulse dump_start with dump_ready=1 -> 32 handshakes, data 0,3,...,93 at idx 0..31; dump_done rises at cycle 64; busy falls.
- Dump with dump_ready toggling 1-in-3 and a CPU write of 0x1234 to word 5 while word 4 is stalled -> data/idx stable under stall; word 5 emits 0x1234.
- Pulse reset=0 mid-dump at idx 10 -> dump_valid=0 and dump_idx=0 immediately (asynchronous); the next start dumps from 0.
- (DMEM_MMIO_EN) Write 1 to 0x8000_0008 -> busy reads 1 next cycle; after 3 memory stores the store counter reads 3; reading 0x8000_000C returns 0.
